// File: rtl/c4_win_scanner.sv
// Sequential Connect-4 win/draw scanner: snapshots the board on start, checks one anchor
// cell per cycle in four directions and reports the first run found with a done pulse.
module c4_win_scanner #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int WIN_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               player,
  input  logic [2*ROWS*COLS-1:0]   board,
  output logic                     busy,
  output logic                     done,
  output logic                     win,
  output logic                     draw,
  output logic [2:0]               win_row,
  output logic [2:0]               win_col,
  output logic [1:0]               win_dir
);

  localparam int CELLS = ROWS * COLS;
  localparam int BW    = 2 * CELLS;
  localparam int AW    = $clog2(CELLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state;
  logic [BW-1:0]   snap_board;
  logic [1:0]      snap_player;
  logic [AW-1:0]   anchor;
  logic [RW-1:0]   cur_row;
  logic [CW-1:0]   cur_col;

  logic [1:0]      cells [ROWS][COLS];
  logic [CELLS-1:0] occupied;
  logic [3:0]      dir_match;
  logic            hit_any;
  logic [1:0]      hit_dir;
  logic            player_ok;
  logic            ok;
  int              rr;
  int              cc;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign cells[r][c]           = snap_board[2*(r*COLS+c) +: 2];
      assign occupied[r*COLS+c]    = |snap_board[2*(r*COLS+c) +: 2];
    end
  end

  // Walk WIN_LEN cells from the current anchor in each direction; off-board cells kill the run.
  always_comb begin
    dir_match = '0;
    ok        = 1'b0;
    rr        = 0;
    cc        = 0;
    player_ok = (snap_player == 2'b01) || (snap_player == 2'b10);
    for (int d = 0; d < 4; d++) begin
      ok = player_ok;
      for (int k = 0; k < WIN_LEN; k++) begin
        rr = int'(cur_row) + ((d == 0) ? 0 : k);
        cc = int'(cur_col) + ((d == 1) ? 0 : ((d == 3) ? -k : k));
        if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS)
          ok = 1'b0;
        else if (cells[rr[RW-1:0]][cc[CW-1:0]] != snap_player)
          ok = 1'b0;
      end
      dir_match[d] = ok;
    end
  end

  always_comb begin
    hit_any = |dir_match;
    if (dir_match[0])      hit_dir = 2'd0;
    else if (dir_match[1]) hit_dir = 2'd1;
    else if (dir_match[2]) hit_dir = 2'd2;
    else                   hit_dir = 2'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      snap_board  <= '0;
      snap_player <= '0;
      anchor      <= '0;
      cur_row     <= '0;
      cur_col     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      win         <= 1'b0;
      draw        <= 1'b0;
      win_row     <= '0;
      win_col     <= '0;
      win_dir     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            snap_board  <= board;
            snap_player <= player;
            anchor      <= '0;
            cur_row     <= '0;
            cur_col     <= '0;
            win         <= 1'b0;
            draw        <= 1'b0;
            win_row     <= '0;
            win_col     <= '0;
            win_dir     <= '0;
            busy        <= 1'b1;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (hit_any) begin
            win     <= 1'b1;
            win_row <= 3'(cur_row);
            win_col <= 3'(cur_col);
            win_dir <= hit_dir;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (anchor == AW'(CELLS-1)) begin
            draw  <= &occupied;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            anchor <= anchor + AW'(1);
            if (cur_col == CW'(COLS-1)) begin
              cur_col <= '0;
              cur_row <= cur_row + RW'(1);
            end else begin
              cur_col <= cur_col + CW'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c4_win_scanner.sv
// Directed bench for c4_win_scanner: expected results are queued when a scan is started and
// popped when done arrives; a small reference scan supplies expectations for random boards.
module tb_c4_win_scanner;

  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int BW   = 2 * ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    player;
  logic [BW-1:0] board;
  logic          busy, done, win, draw;
  logic [2:0]    win_row, win_col;
  logic [1:0]    win_dir;

  typedef struct {
    string      tag;
    logic       win;
    logic       draw;
    logic [2:0] row;
    logic [2:0] col;
    logic [1:0] dir;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  c4_win_scanner #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(4)) dut (
    .clk(clk), .rst(rst), .start(start), .player(player), .board(board),
    .busy(busy), .done(done), .win(win), .draw(draw),
    .win_row(win_row), .win_col(win_col), .win_dir(win_dir)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [BW-1:0] setc(input logic [BW-1:0] b, input int r, input int c,
                                         input logic [1:0] v);
    logic [6:0] bi;
    bi = 7'(2*(r*COLS+c));
    b[bi +: 2] = v;
    return b;
  endfunction

  function automatic exp_t mk(input logic w, input logic d, input int row, input int col,
                              input int dir, input int lat);
    exp_t e;
    e.tag  = "";
    e.win  = w;
    e.draw = d;
    e.row  = 3'(row);
    e.col  = 3'(col);
    e.dir  = 2'(dir);
    e.lat  = lat;
    return e;
  endfunction

  // Reference scan: first anchor in row-major order, lowest direction wins.
  function automatic exp_t model(input logic [BW-1:0] b, input logic [1:0] p);
    exp_t e;
    int   dr [4] = '{0, 1, 1, 1};
    int   dc [4] = '{1, 0, 1, -1};
    bit   found = 0;
    bit   hit;
    bit   full = 1;
    int   rr, cc;
    logic [6:0] bi;
    e = mk(0, 0, 0, 0, 0, ROWS*COLS);
    for (int i = 0; i < ROWS*COLS; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (!found) begin
          hit = (p == 2'b01) || (p == 2'b10);
          for (int k = 0; k < 4; k++) begin
            rr = i / COLS + dr[d] * k;
            cc = i % COLS + dc[d] * k;
            if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) hit = 0;
            else begin
              bi = 7'(2*(rr*COLS+cc));
              if (b[bi +: 2] != p) hit = 0;
            end
          end
          if (hit) begin
            found = 1;
            e = mk(1, 0, i / COLS, i % COLS, d, i + 1);
          end
        end
      end
    end
    for (int i = 0; i < ROWS*COLS; i++) begin
      bi = 7'(2*i);
      if (b[bi +: 2] == 2'b00) full = 0;
    end
    if (!found) e.draw = full;
    return e;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", name, obs, expv);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [BW-1:0] b, input logic [1:0] p,
                               input exp_t e);
    @(negedge clk);
    board  = b;
    player = p;
    start  = 1'b1;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for done (bounded), optionally firing a stray start mid-scan, then compare.
  task automatic checkOutput(input int extra_at, input logic [BW-1:0] extra_board);
    exp_t e;
    int   n = 0;
    int   busy_cnt = 0;
    e = sb.pop_front();
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (n == extra_at) begin
        board  = extra_board;
        player = 2'b01;
        start  = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    checkVal($sformatf("%s done_seen", e.tag), 32'(done), 1);
    checkVal($sformatf("%s latency", e.tag), n, e.lat);
    checkVal($sformatf("%s busy_cycles", e.tag), busy_cnt, e.lat);
    checkVal($sformatf("%s busy_at_done", e.tag), 32'(busy), 0);
    checkVal($sformatf("%s win", e.tag), 32'(win), 32'(e.win));
    checkVal($sformatf("%s draw", e.tag), 32'(draw), 32'(e.draw));
    checkVal($sformatf("%s win_row", e.tag), 32'(win_row), 32'(e.row));
    checkVal($sformatf("%s win_col", e.tag), 32'(win_col), 32'(e.col));
    checkVal($sformatf("%s win_dir", e.tag), 32'(win_dir), 32'(e.dir));
    @(posedge clk);
    #1;
    checkVal($sformatf("%s done_pulse", e.tag), 32'(done), 0);
    checkVal($sformatf("%s win_hold", e.tag), 32'(win), 32'(e.win));
    checkVal($sformatf("%s draw_hold", e.tag), 32'(draw), 32'(e.draw));
  endtask

  initial begin
    logic [BW-1:0] b, row_wrap, diag_ur, diag_ul, full_b, rnd;
    int            done_cnt;

    rst    = 1'b1;
    start  = 1'b0;
    player = 2'b00;
    board  = '0;
    #1;
    checkVal("reset busy", 32'(busy), 0);
    checkVal("reset done", 32'(done), 0);
    checkVal("reset win", 32'(win), 0);
    checkVal("reset draw", 32'(draw), 0);
    checkVal("reset win_pos", {26'd0, win_row, win_col}, 0);
    checkVal("reset win_dir", 32'(win_dir), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus("empty", '0, 2'b01, mk(0, 0, 0, 0, 0, 42));
    checkOutput(-1, '0);

    b = '0;
    for (int c = 0; c < 4; c++) b = setc(b, 0, c, 2'b01);
    applyStimulus("horiz", b, 2'b01, mk(1, 0, 0, 0, 0, 1));
    checkOutput(-1, '0);

    b = '0;
    for (int r = 2; r < 6; r++) b = setc(b, r, 6, 2'b10);
    applyStimulus("vert_p2", b, 2'b10, mk(1, 0, 2, 6, 1, 21));
    checkOutput(-1, '0);

    diag_ul = '0;
    for (int k = 0; k < 4; k++) diag_ul = setc(diag_ul, k, 3 - k, 2'b01);
    applyStimulus("diag_ul", diag_ul, 2'b01, mk(1, 0, 0, 3, 3, 4));
    checkOutput(-1, '0);
    applyStimulus("diag_ul_p2", diag_ul, 2'b10, mk(0, 0, 0, 0, 0, 42));
    checkOutput(-1, '0);

    row_wrap = '0;
    row_wrap = setc(row_wrap, 0, 4, 2'b01);
    row_wrap = setc(row_wrap, 0, 5, 2'b01);
    row_wrap = setc(row_wrap, 0, 6, 2'b01);
    row_wrap = setc(row_wrap, 1, 0, 2'b01);
    applyStimulus("row_wrap", row_wrap, 2'b01, mk(0, 0, 0, 0, 0, 42));
    checkOutput(-1, '0);

    diag_ur = '0;
    for (int k = 0; k < 4; k++) diag_ur = setc(diag_ur, k, k, 2'b01);
    applyStimulus("diag_ur", diag_ur, 2'b01, mk(1, 0, 0, 0, 2, 1));
    checkOutput(-1, '0);

    // Full board whose colour flips with row and with each column pair: no run of four.
    full_b = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        full_b = setc(full_b, r, c, (((c / 2) + r) % 2 == 0) ? 2'b01 : 2'b10);
    applyStimulus("full_draw", full_b, 2'b01, mk(0, 1, 0, 0, 0, 42));
    checkOutput(10, diag_ur);
    done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
    end
    checkVal("ignored_start no_done", done_cnt, 0);
    checkVal("ignored_start draw_hold", 32'(draw), 1);

    applyStimulus("full_p11", full_b, 2'b11, mk(0, 1, 0, 0, 0, 42));
    checkOutput(-1, '0);

    for (int t = 0; t < 3; t++) begin
      rnd = '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          rnd = setc(rnd, r, c, 2'($urandom_range(0, 2)));
      applyStimulus($sformatf("rand%0d", t), rnd, (t % 2 == 0) ? 2'b01 : 2'b10,
                    model(rnd, (t % 2 == 0) ? 2'b01 : 2'b10));
      checkOutput(-1, '0);
    end

    applyStimulus("pre_reset_win", diag_ur, 2'b01, mk(1, 0, 0, 0, 2, 1));
    checkOutput(-1, '0);
    @(negedge clk);
    board  = '0;
    player = 2'b01;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkVal("midscan busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    #1;
    checkVal("midscan rst busy", 32'(busy), 0);
    checkVal("midscan rst done", 32'(done), 0);
    checkVal("midscan rst win_draw", {30'd0, win, draw}, 0);
    checkVal("midscan rst win_pos", {24'd0, win_dir, win_row, win_col}, 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    checkVal("midscan no_done_after_rst", done_cnt, 0);

    b = '0;
    for (int c = 0; c < 4; c++) b = setc(b, 0, c, 2'b01);
    applyStimulus("post_reset_horiz", b, 2'b01, mk(1, 0, 0, 0, 0, 1));
    checkOutput(-1, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
